// File: rtl/sized_data_ram_pkg.sv
// Shared encodings for sized_data_ram: access sizes, FSM states, size-to-byte-count helper.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package sized_ram_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/sized_data_ram_load_ext.sv
// Sign/zero extension of LSB-aligned load bytes to DATA_W by access size.
// Latency: combinational.
// Backpressure: none, pure function of inputs.
module ram_load_ext #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] raw,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] data
);
    import sized_ram_pkg::*;

    logic sign_bit;

    always_comb begin
        case (size)
            SZ_BYTE: sign_bit = raw[7];
            SZ_HALF: sign_bit = raw[15];
            SZ_WORD: sign_bit = raw[31];
            default: sign_bit = raw[DATA_W-1];
        endcase
        sign_bit = sign_bit & ~is_unsigned;
        data     = '0;
        for (int b = 0; b < DATA_W; b++) begin
            data[b] = (b < 8 * int'(size_bytes(size))) ? raw[b] : sign_bit;
        end
    end

endmodule

// File: rtl/sized_data_ram.sv
// Byte-addressed RAM with sized loads/stores; define MISALIGN_CHECK_EN to reject misaligned accesses.
// Latency: accept at edge k, resp_valid after edge k+1+LATENCY; one request outstanding.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready.
module sized_data_ram #(
    parameter int         DATA_W     = 32,
    parameter int         SIZE       = 1024,
    parameter int         LATENCY    = 0,
    parameter logic [7:0] RESET_FILL = 8'hAA
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);
    import sized_ram_pkg::*;

    localparam int AW = $clog2(SIZE);
    localparam int NB = DATA_W / 8;

    logic [7:0]        mem [SIZE];
    state_e            state_q, state_d;
    logic [3:0]        cnt_q;
    logic              wr_q, uns_q, err_q;
    logic [1:0]        size_q;
    logic [AW-1:0]     addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q, raw, ext_data;
    logic              commit, misalign, err_c;
    logic              unused_addr;

    // Only the in-range address bits select a byte; upper bits alias by design.
    assign unused_addr = ^req_addr[DATA_W-1:AW];

    assign commit = (state_q == ST_WAIT) && (cnt_q == 4'd0);

`ifdef MISALIGN_CHECK_EN
    assign misalign = |(addr_q & AW'(size_bytes(size_q) - 4'd1));
`else
    assign misalign = 1'b0;
`endif

    assign err_c = ((DATA_W == 32) && (size_q == SZ_DWORD)) || misalign;

    always_comb begin
        raw = '0;
        for (int i = 0; i < NB; i++) begin
            raw[i*8 +: 8] = mem[addr_q + AW'(i)];
        end
    end

    ram_load_ext #(.DATA_W(DATA_W)) u_load_ext (
        .raw         (raw),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (ext_data)
    );

    // Storage: reset refills every byte, so a request dropped by reset leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SIZE; i++) begin
                mem[i] <= RESET_FILL;
            end
        end else if (commit && wr_q && !err_c) begin
            for (int i = 0; i < NB; i++) begin
                if (i < int'(size_bytes(size_q))) begin
                    mem[addr_q + AW'(i)] <= wdata_q[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == 4'd0) state_d = ST_RESP;
            ST_RESP: if (resp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = (state_q == ST_RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && req_valid) begin
                cnt_q   <= 4'(LATENCY);
                wr_q    <= req_write;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr[AW-1:0];
                wdata_q <= req_wdata;
            end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (commit) begin
                err_q   <= err_c;
                rdata_q <= (!wr_q && !err_c) ? ext_data : '0;
            end else if (state_q == ST_RESP && resp_ready) begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sized_data_ram.sv
// Directed bench for sized_data_ram (DATA_W=32, SIZE=1024, LATENCY=3) with a response scoreboard.
module tb_sized_data_ram;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int failures = 0;
    logic [32:0] exp_q [$];

    sized_data_ram #(
        .DATA_W(32), .SIZE(1024), .LATENCY(LAT), .RESET_FILL(8'hAA)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction: expectation queued at issue, compared when the response appears.
    task automatic xact(input string tag, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_data, input logic exp_err, input int hold);
        int cyc;
        logic [32:0] e;
        exp_q.push_back({exp_err, exp_data});
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = d;
        chk({tag, ".req_ready_idle"}, 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk({tag, ".req_ready_wait"}, 64'(req_ready), 64'd0);
        cyc = 0;
        while (!resp_valid && cyc < 40) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk({tag, ".resp_valid"}, 64'(resp_valid), 64'd1);
        chk({tag, ".latency"}, 64'(cyc), 64'(LAT + 1));
        e = exp_q.pop_front();
        chk({tag, ".rdata"}, 64'(resp_rdata), 64'(e[31:0]));
        chk({tag, ".err"}, 64'(resp_err), 64'(e[32]));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold_valid"}, 64'(resp_valid), 64'd1);
            chk({tag, ".hold_rdata"}, 64'(resp_rdata), 64'(e[31:0]));
            chk({tag, ".hold_req_ready"}, 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk({tag, ".resp_done"}, 64'(resp_valid), 64'd0);
        chk({tag, ".err_cleared"}, 64'(resp_err), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset.req_ready", 64'(req_ready), 64'd1);
        chk("reset.resp_valid", 64'(resp_valid), 64'd0);
        chk("reset.rdata", 64'(resp_rdata), 64'd0);
        chk("reset.err", 64'(resp_err), 64'd0);
        rst_n = 1'b1;

        xact("t1.ld_word_fill", 0, 2'b10, 0, 32'h10, 0, 32'hAAAAAAAA, 0, 0);

        xact("t2.st_word", 1, 2'b10, 0, 32'h8, 32'hDEADBEEF, 32'h0, 0, 0);
        xact("t2.ld_sbyte", 0, 2'b00, 0, 32'h8, 0, 32'hFFFFFFEF, 0, 0);
        xact("t2.ld_uhalf", 0, 2'b01, 1, 32'hA, 0, 32'h0000DEAD, 0, 0);
        xact("t2.ld_shalf", 0, 2'b01, 0, 32'hA, 0, 32'hFFFFDEAD, 0, 0);
        xact("t2.ld_ubyte", 0, 2'b00, 1, 32'hB, 0, 32'h000000DE, 0, 0);
        xact("t2.ld_word", 0, 2'b10, 0, 32'h8, 0, 32'hDEADBEEF, 0, 0);

`ifndef MISALIGN_CHECK_EN
        xact("t3.st_wrap", 1, 2'b10, 0, 32'd1022, 32'h11223344, 32'h0, 0, 0);
        xact("t3.b1022", 0, 2'b00, 1, 32'd1022, 0, 32'h44, 0, 0);
        xact("t3.b1023", 0, 2'b00, 1, 32'd1023, 0, 32'h33, 0, 0);
        xact("t3.b0", 0, 2'b00, 1, 32'd0, 0, 32'h22, 0, 0);
        xact("t3.b1", 0, 2'b00, 1, 32'd1, 0, 32'h11, 0, 0);
        xact("t3.ld_wrap", 0, 2'b10, 0, 32'd1022, 0, 32'h11223344, 0, 0);
`endif

        xact("t4.hold", 0, 2'b10, 0, 32'h8, 0, 32'hDEADBEEF, 0, 3);

        xact("t5.ld_dword", 0, 2'b11, 0, 32'h20, 0, 32'h0, 1, 0);
        xact("t5.st_dword", 1, 2'b11, 0, 32'h20, 32'h01234567, 32'h0, 1, 1);
        xact("t5.unchanged", 0, 2'b10, 0, 32'h20, 0, 32'hAAAAAAAA, 0, 0);
`ifdef MISALIGN_CHECK_EN
        xact("t5.st_half_mis", 1, 2'b01, 0, 32'h3, 32'hBEEF, 32'h0, 1, 0);
        xact("t5.b3", 0, 2'b00, 1, 32'h3, 0, 32'hAA, 0, 0);
        xact("t5.b4", 0, 2'b00, 1, 32'h4, 0, 32'hAA, 0, 0);
`endif

        // Reset during WAIT of a store: request is dropped and memory refilled.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h12345678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6.no_resp_in_reset", 64'(resp_valid), 64'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6.no_resp_after", 64'(resp_valid), 64'd0);
        end
        xact("t6.target_fill", 0, 2'b10, 0, 32'h40, 0, 32'hAAAAAAAA, 0, 0);
        xact("t6.old_refilled", 0, 2'b10, 0, 32'h8, 0, 32'hAAAAAAAA, 0, 0);

        chk("scoreboard.empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
